switch_event: RTL and testbench

- Consumes the debounced switch level produced by the board switch debouncer.
- Turns that level into discrete, handshaked button events: PRESS, LONG, REPEAT and RELEASE.
- Sits between the debouncer and board-test/CPU control logic (single-step, byte entry), so consumers never edge-detect or time presses themselves.
- Holds each event in a one-deep valid/ready output register.

---
 rtl/bf_board_pkg.sv | 15 +
 rtl/switch_event.sv | 112 +++++++++++
 tb/tb_switch_event.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/bf_board_pkg.sv
// Shared board-level definitions: button event codes and the switch_event state encoding.
package bf_board_pkg;

   localparam logic [1:0] EV_RELEASE = 2'b00;
   localparam logic [1:0] EV_PRESS   = 2'b01;
   localparam logic [1:0] EV_LONG    = 2'b10;
   localparam logic [1:0] EV_REPEAT  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_PRESSED = 2'b01,
      ST_HELD    = 2'b10
   } sw_state_t;

endpackage

// File: rtl/switch_event.sv
// Turns a debounced switch level into PRESS/LONG/REPEAT/RELEASE events held in a
// one-deep valid/ready register; the FSM keeps running under backpressure.
module switch_event
   import bf_board_pkg::*;
#(
   parameter int unsigned LONG_CYCLES   = 12_000_000,
   parameter int unsigned REPEAT_CYCLES = 3_000_000,
   parameter int unsigned CNT_W         = 24
) (
   input  logic       sys_clock,
   input  logic       sys_reset,
   input  logic       switch_level,
   output logic       event_valid,
   output logic [1:0] event_type,
   input  logic       event_ready,
   output logic       pressed,
   output logic [7:0] press_count,
   output logic       overrun
);

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   sw_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_event_valid;
   logic [1:0]       r_event_type;
   logic             r_pressed;
   logic [7:0]       r_press_count;
   logic             r_overrun;

   sw_state_t        w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_gen;
   logic [1:0]       w_type;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_gen       = 1'b0;
      w_type      = EV_RELEASE;
      unique case (r_state)
         ST_IDLE: begin
            w_cnt_nxt = '0;
            if (switch_level) begin
               w_gen       = 1'b1;
               w_type      = EV_PRESS;
               w_state_nxt = ST_PRESSED;
            end
         end
         ST_PRESSED, ST_HELD: begin
            // Release wins over a timer expiry landing in the same cycle.
            if (!switch_level) begin
               w_gen       = 1'b1;
               w_type      = EV_RELEASE;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_IDLE;
            end else if (r_state == ST_PRESSED && r_cnt == LONG_LAST) begin
               w_gen       = 1'b1;
               w_type      = EV_LONG;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_HELD;
            end else if (r_state == ST_HELD && r_cnt == REPEAT_LAST) begin
               w_gen     = 1'b1;
               w_type    = EV_REPEAT;
               w_cnt_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge sys_clock) begin
      if (sys_reset) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_event_valid <= 1'b0;
         r_event_type  <= EV_RELEASE;
         r_pressed     <= 1'b0;
         r_press_count <= '0;
         r_overrun     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_pressed <= switch_level;
         if (w_gen && w_type == EV_PRESS)
            r_press_count <= r_press_count + 8'd1;
         if (w_gen) begin
            if (!r_event_valid || event_ready) begin
               r_event_valid <= 1'b1;
               r_event_type  <= w_type;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_event_valid && event_ready) begin
            r_event_valid <= 1'b0;
         end
      end
   end

   assign event_valid = r_event_valid;
   assign event_type  = r_event_type;
   assign pressed     = r_pressed;
   assign press_count = r_press_count;
   assign overrun     = r_overrun;

endmodule

// File: tb/tb_switch_event.sv
// Scoreboard bench for switch_event with short LONG/REPEAT timers.
module tb_switch_event;
   import bf_board_pkg::*;

   localparam int unsigned L   = 8;
   localparam int unsigned REP = 4;

   logic       sys_clock = 1'b0;
   logic       sys_reset;
   logic       switch_level;
   logic       event_valid;
   logic [1:0] event_type;
   logic       event_ready;
   logic       pressed;
   logic [7:0] press_count;
   logic       overrun;

   typedef struct {
      logic [1:0] t;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   exp_cnt  = 0;

   switch_event #(.LONG_CYCLES(L), .REPEAT_CYCLES(REP), .CNT_W(8)) dut (
      .sys_clock   (sys_clock),
      .sys_reset   (sys_reset),
      .switch_level(switch_level),
      .event_valid (event_valid),
      .event_type  (event_type),
      .event_ready (event_ready),
      .pressed     (pressed),
      .press_count (press_count),
      .overrun     (overrun)
   );

   always #5 sys_clock = ~sys_clock;
   always @(posedge sys_clock) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input int got, input int want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   task automatic push(input logic [1:0] t, input int c);
      exp_t e;
      e.t   = t;
      e.cyc = c;
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge sys_clock);
      #1;
   endtask

   // An event seen with ready high at the negedge is accepted at the next edge.
   always @(negedge sys_clock) begin
      if (!sys_reset && event_valid && event_ready) begin
         if (q.size() == 0) begin
            check_eq("unexpected_event", int'(event_type), -1);
         end else begin
            exp_t e;
            e = q.pop_front();
            check_eq("ev_type", int'(event_type), int'(e.t));
            if (e.cyc >= 0) check_eq("ev_cycle", cyc, e.cyc);
         end
      end
   end

   // Rise at cycle c, hold h edges, drop at c+h; model the event schedule directly.
   task automatic press_hold(input int h);
      int c;
      c = cyc;
      switch_level = 1'b1;
      exp_cnt++;
      push(EV_PRESS, c + 1);
      if (h > int'(L)) push(EV_LONG, c + 1 + int'(L));
      for (int k = 1; int'(L + REP * k) <= h - 1; k++)
         push(EV_REPEAT, c + 1 + int'(L + REP * k));
      push(EV_RELEASE, c + h + 1);
      step();
      check_eq("pressed_rise", int'(pressed), 1);
      repeat (h - 1) step();
      switch_level = 1'b0;
      repeat (3) step();
      check_eq("sb_drained", q.size(), 0);
      check_eq("press_count", int'(press_count), exp_cnt);
      check_eq("pressed_fall", int'(pressed), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      sys_reset    = 1'b1;
      switch_level = 1'b0;
      event_ready  = 1'b1;
      repeat (3) step();
      sys_reset = 1'b0;
      check_eq("rst_valid",   int'(event_valid), 0);
      check_eq("rst_type",    int'(event_type), 0);
      check_eq("rst_pressed", int'(pressed), 0);
      check_eq("rst_count",   int'(press_count), 0);
      check_eq("rst_overrun", int'(overrun), 0);
      repeat (5) step();

      press_hold(3);        // short press, no LONG
      repeat (2) step();
      press_hold(30);       // LONG then REPEATs
      repeat (2) step();
      press_hold(int'(L));  // drop exactly on LONG expiry
      check_eq("expiry_valid", int'(event_valid), 0);
      check_eq("overrun_clean", int'(overrun), 0);

      // Backpressure: RELEASE is dropped while PRESS is pending.
      event_ready  = 1'b0;
      switch_level = 1'b1;
      exp_cnt++;
      push(EV_PRESS, -1);
      step();
      check_eq("bp_valid", int'(event_valid), 1);
      check_eq("bp_type",  int'(event_type), int'(EV_PRESS));
      check_eq("bp_ovr0",  int'(overrun), 0);
      switch_level = 1'b0;
      step();
      check_eq("bp_ovr1",   int'(overrun), 1);
      check_eq("bp_valid2", int'(event_valid), 1);
      check_eq("bp_type2",  int'(event_type), int'(EV_PRESS));
      event_ready = 1'b1;
      step();
      check_eq("bp_drain",  int'(event_valid), 0);
      check_eq("bp_count",  int'(press_count), exp_cnt);
      check_eq("bp_sticky", int'(overrun), 1);
      check_eq("bp_sb",     q.size(), 0);
      repeat (2) step();

      // Reset while in HELD with the switch still down.
      c = cyc;
      switch_level = 1'b1;
      push(EV_PRESS, c + 1);
      push(EV_LONG, c + 1 + int'(L));
      repeat (L + 2) step();
      check_eq("held_sb", q.size(), 0);
      sys_reset = 1'b1;
      repeat (2) step();
      check_eq("mr_valid",   int'(event_valid), 0);
      check_eq("mr_type",    int'(event_type), 0);
      check_eq("mr_pressed", int'(pressed), 0);
      check_eq("mr_count",   int'(press_count), 0);
      check_eq("mr_overrun", int'(overrun), 0);
      exp_cnt = 1;
      push(EV_PRESS, cyc + 1);
      sys_reset = 1'b0;
      repeat (2) step();
      check_eq("mr_press_sb", q.size(), 0);
      check_eq("mr_count1",   int'(press_count), 1);
      push(EV_RELEASE, cyc + 1);
      switch_level = 1'b0;
      repeat (3) step();
      check_eq("final_sb", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
